// File: rtl/adc_spi_deserializer.sv
// adc_spi_deserializer: SPI master for AD7476-style ADCs (e.g. PmodAD1).
// Drives SCLK/CSn, shifts CHANNELS SDATA lines in MSB first, drops the
// leading zero bits, and presents one DATA_W word per channel.
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   start_i           single-shot request, honoured only when idle
//   continuous_i      repeat frames separated by QUIET_CYC cycles
//   sclk_o, csn_o     serial clock (idles high), chip select (active low)
//   sdata_i           one serial data bit per channel
//   dataout_o         channel c in bits [c*DATA_W +: DATA_W]
//   valid_o           one-cycle strobe when dataout_o updates
//   lead_err_o        some channel had a non-zero leading bit in that frame
//   busy_o            high while a frame or quiet gap is in progress
module adc_spi_deserializer #(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int CHANNELS  = 2,
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         continuous_i,
    output logic                         sclk_o,
    output logic                         csn_o,
    input  logic [CHANNELS-1:0]          sdata_i,
    output logic [CHANNELS*DATA_W-1:0]   dataout_o,
    output logic                         valid_o,
    output logic                         lead_err_o,
    output logic                         busy_o
);

    localparam int FRAME_BITS = LEAD_BITS + DATA_W;
    localparam int HC_W = $clog2(CLK_DIV + 1);
    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam int QC_W = $clog2(QUIET_CYC + 1);

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS - 1);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUIET_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        QUIET = 2'd2
    } state_e;

    state_e state_q;

    logic sclk_q;
    logic csn_q;
    logic valid_q;
    logic lead_err_q;
    logic lead_acc_q;
    logic busy_q;

    logic [HC_W-1:0] hc_q;
    logic [BC_W-1:0] bc_q;
    logic [QC_W-1:0] qc_q;

    logic [CHANNELS-1:0][DATA_W-1:0] shift_q;
    logic [CHANNELS-1:0][DATA_W-1:0] shift_d;
    logic [CHANNELS-1:0][DATA_W-1:0] dout_q;

    logic is_lead;
    logic frame_go;

    // Bit index still inside the leading-zero field of the frame.
    if (LEAD_BITS > 0) begin : g_lead
        assign is_lead = (bc_q < BC_W'(LEAD_BITS));
    end else begin : g_nolead
        assign is_lead = 1'b0;
    end

    always_comb begin
        shift_d = shift_q;
        for (int c = 0; c < CHANNELS; c++) begin
            shift_d[c] = {shift_q[c][DATA_W-2:0], sdata_i[c]};
        end
    end

    // A frame starts from IDLE on either request, or back-to-back
    // after the quiet gap while continuous mode is still requested.
    assign frame_go = ((state_q == IDLE) && (start_i || continuous_i))
                   || ((state_q == QUIET) && (qc_q == QC_LAST)
                       && continuous_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sclk_q     <= 1'b1;
            csn_q      <= 1'b1;
            valid_q    <= 1'b0;
            lead_err_q <= 1'b0;
            lead_acc_q <= 1'b0;
            busy_q     <= 1'b0;
            hc_q       <= '0;
            bc_q       <= '0;
            qc_q       <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (frame_go) begin
                state_q    <= FRAME;
                csn_q      <= 1'b0;
                sclk_q     <= 1'b0;
                busy_q     <= 1'b1;
                hc_q       <= '0;
                bc_q       <= '0;
                qc_q       <= '0;
                lead_acc_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    FRAME: begin
                        if (hc_q == HC_LAST) begin
                            hc_q <= '0;
                            if (!sclk_q) begin
                                // Last cycle of the low phase: sample.
                                sclk_q <= 1'b1;
                                if (is_lead) begin
                                    lead_acc_q <= lead_acc_q | (|sdata_i);
                                end else begin
                                    shift_q <= shift_d;
                                end
                            end else if (bc_q == BC_LAST) begin
                                state_q    <= QUIET;
                                csn_q      <= 1'b1;
                                valid_q    <= 1'b1;
                                dout_q     <= shift_q;
                                lead_err_q <= lead_acc_q;
                                qc_q       <= '0;
                            end else begin
                                sclk_q <= 1'b0;
                                bc_q   <= bc_q + BC_W'(1);
                            end
                        end else begin
                            hc_q <= hc_q + HC_W'(1);
                        end
                    end
                    QUIET: begin
                        if (qc_q == QC_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            qc_q    <= '0;
                        end else begin
                            qc_q <= qc_q + QC_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sclk_o     = sclk_q;
    assign csn_o      = csn_q;
    assign dataout_o  = dout_q;
    assign valid_o    = valid_q;
    assign lead_err_o = lead_err_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_adc_spi_deserializer.sv
// Bench for adc_spi_deserializer: default instance plus a small
// single-channel instance, each fed by a behavioural ADC model.
module tb_adc_spi_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic cont_a = 1'b0;
    logic start_b = 1'b0;
    logic cont_b = 1'b0;

    logic [1:0]  sdata_a = 2'b00;
    logic [0:0]  sdata_b = 1'b0;
    logic        sclk_a, csn_a, valid_a, lerr_a, busy_a;
    logic        sclk_b, csn_b, valid_b, lerr_b, busy_b;
    logic [23:0] dout_a;
    logic [7:0]  dout_b;

    adc_spi_deserializer dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .continuous_i(cont_a), .sclk_o(sclk_a), .csn_o(csn_a),
        .sdata_i(sdata_a), .dataout_o(dout_a), .valid_o(valid_a),
        .lead_err_o(lerr_a), .busy_o(busy_a)
    );

    adc_spi_deserializer #(
        .DATA_W(8), .LEAD_BITS(0), .CHANNELS(1),
        .CLK_DIV(1), .QUIET_CYC(1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .continuous_i(cont_b), .sclk_o(sclk_b), .csn_o(csn_b),
        .sdata_i(sdata_b), .dataout_o(dout_b), .valid_o(valid_b),
        .lead_err_o(lerr_b), .busy_o(busy_b)
    );

    // ---- ADC models: a new frame word per CSn fall, next bit per SCLK rise
    typedef logic [1:0][15:0] frame_a_t;
    frame_a_t   qa[$];
    frame_a_t   cur_a = '0;
    int         idx_a = 0;
    logic [7:0] qb[$];
    logic [7:0] cur_b = '0;
    int         idx_b = 0;

    function automatic logic [1:0] bits_a(frame_a_t f, int i);
        logic [1:0] b;
        b = 2'b00;
        if (i >= 0 && i < 16)
            for (int c = 0; c < 2; c++) b[c] = f[c][15-i];
        return b;
    endfunction

    function automatic logic bit_b(logic [7:0] v, int i);
        logic b;
        b = 1'b0;
        if (i >= 0 && i < 8) b = v[7-i];
        return b;
    endfunction

    always @(negedge csn_a) begin
        if (qa.size() > 0) cur_a = qa.pop_front();
        else cur_a = '0;
        idx_a = 0;
        sdata_a = bits_a(cur_a, idx_a);
    end

    always @(posedge sclk_a) begin
        if (csn_a === 1'b0) begin
            idx_a++;
            sdata_a = bits_a(cur_a, idx_a);
        end
    end

    always @(negedge csn_b) begin
        if (qb.size() > 0) cur_b = qb.pop_front();
        else cur_b = '0;
        idx_b = 0;
        sdata_b[0] = bit_b(cur_b, idx_b);
    end

    always @(posedge sclk_b) begin
        if (csn_b === 1'b0) begin
            idx_b++;
            sdata_b[0] = bit_b(cur_b, idx_b);
        end
    end

    // ---- Reference model
    function automatic logic [23:0] data_a(frame_a_t f);
        return {f[1][11:0], f[0][11:0]};
    endfunction

    function automatic logic lead_a(frame_a_t f);
        return (|f[1][15:12]) | (|f[0][15:12]);
    endfunction

    // Expected {csn, sclk, valid, busy} k cycles after the request
    // cycle, for nfr frames of f cycles, q quiet cycles, d half-period.
    function automatic logic [3:0] pins(int k, int nfr, int f, int q,
                                        int d);
        int j;
        int r;
        logic s;
        if (k < 1) return 4'b1100;
        j = (k - 1) / (f + q);
        r = (k - 1) % (f + q);
        if (j >= nfr) return 4'b1100;
        if (r < f) begin
            s = ((r / d) % 2) == 1;
            return {1'b0, s, 1'b0, 1'b1};
        end
        return {1'b1, 1'b1, r == f, 1'b1};
    endfunction

    function automatic frame_a_t rand_frame(bit allow_lead);
        frame_a_t f;
        for (int c = 0; c < 2; c++) begin
            f[c][11:0] = 12'($urandom);
            if (allow_lead && $urandom_range(0, 2) == 0)
                f[c][15:12] = 4'($urandom_range(1, 15));
            else
                f[c][15:12] = 4'h0;
        end
        return f;
    endfunction

    // ---- Tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({csn_a, sclk_a, valid_a, busy_a, lerr_a} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_a_ctrl got=%b exp=11000",
                     {csn_a, sclk_a, valid_a, busy_a, lerr_a});
        end
        vectors++;
        if (dout_a !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_a_data got=%h exp=000000", dout_a);
        end
        vectors++;
        if ({csn_b, sclk_b, valid_b, busy_b, lerr_b} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_b_ctrl got=%b exp=11000",
                     {csn_b, sclk_b, valid_b, busy_b, lerr_b});
        end
        vectors++;
        if (dout_b !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_b_data got=%h exp=00", dout_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        frame_a_t fr;
        logic [3:0] exp;
        fr[0] = 16'h0C93;
        fr[1] = 16'h0895;
        qa.push_back(fr);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= 140; k++) begin
            exp = pins(k, 1, 128, 8, 4);
            vectors++;
            if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                miscompares++;
                $display("FAIL single_pins k=%0d got=%b exp=%b", k,
                         {csn_a, sclk_a, valid_a, busy_a}, exp);
            end
            if (exp[1]) begin
                vectors++;
                if ({lerr_a, dout_a} !== {lead_a(fr), data_a(fr)}) begin
                    miscompares++;
                    $display("FAIL single_data got=%b_%h exp=%b_%h",
                             lerr_a, dout_a, lead_a(fr), data_a(fr));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_continuous();
        frame_a_t frs[2];
        logic [3:0] exp;
        int nv;
        nv = 0;
        frs[0][0] = 16'h0589;
        frs[0][1] = {4'h0, 12'($urandom)};
        frs[1][0] = 16'h0AAA;
        frs[1][1] = {4'h0, 12'($urandom)};
        qa.push_back(frs[0]);
        qa.push_back(frs[1]);
        cont_a = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 280; k++) begin
            exp = pins(k, 2, 128, 8, 4);
            vectors++;
            if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                miscompares++;
                $display("FAIL cont_pins k=%0d got=%b exp=%b", k,
                         {csn_a, sclk_a, valid_a, busy_a}, exp);
            end
            if (exp[1]) begin
                vectors++;
                if ({lerr_a, dout_a} !== {lead_a(frs[nv]),
                                          data_a(frs[nv])}) begin
                    miscompares++;
                    $display("FAIL cont_data k=%0d got=%h exp=%h", k,
                             dout_a, data_a(frs[nv]));
                end
                if (nv < 1) nv++;
            end
            if (k == 200) cont_a = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_lead_err();
        frame_a_t fr;
        logic [3:0] exp;
        for (int i = 0; i < 2; i++) begin
            fr = rand_frame(1'b0);
            if (i == 0) fr[1] = 16'h1FDF;
            qa.push_back(fr);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            for (int k = 1; k <= 137; k++) begin
                exp = pins(k, 1, 128, 8, 4);
                vectors++;
                if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                    miscompares++;
                    $display("FAIL lead_pins k=%0d got=%b exp=%b", k,
                             {csn_a, sclk_a, valid_a, busy_a}, exp);
                end
                if (exp[1]) begin
                    vectors++;
                    if ({lerr_a, dout_a} !== {lead_a(fr), data_a(fr)}) begin
                        miscompares++;
                        $display("FAIL lead_data i=%0d got=%b_%h exp=%b_%h",
                                 i, lerr_a, dout_a, lead_a(fr), data_a(fr));
                    end
                    if (i == 0) begin
                        vectors++;
                        if (dout_a[23:12] !== 12'hFDF) begin
                            miscompares++;
                            $display("FAIL lead_ch1 got=%h exp=fdf",
                                     dout_a[23:12]);
                        end
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random();
        frame_a_t fr;
        logic [3:0] exp;
        for (int i = 0; i < 6; i++) begin
            fr = rand_frame(1'b1);
            qa.push_back(fr);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            for (int k = 1; k <= 137; k++) begin
                exp = pins(k, 1, 128, 8, 4);
                vectors++;
                if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                    miscompares++;
                    $display("FAIL rand_pins k=%0d got=%b exp=%b", k,
                             {csn_a, sclk_a, valid_a, busy_a}, exp);
                end
                if (exp[1]) begin
                    vectors++;
                    if ({lerr_a, dout_a} !== {lead_a(fr), data_a(fr)}) begin
                        miscompares++;
                        $display("FAIL rand_data i=%0d got=%b_%h exp=%b_%h",
                                 i, lerr_a, dout_a, lead_a(fr), data_a(fr));
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        frame_a_t fr;
        logic [3:0] exp;
        qa.push_back(rand_frame(1'b1));
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k < 60; k++) begin
            exp = pins(k, 1, 128, 8, 4);
            vectors++;
            if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                miscompares++;
                $display("FAIL rmid_pins k=%0d got=%b exp=%b", k,
                         {csn_a, sclk_a, valid_a, busy_a}, exp);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({csn_a, sclk_a, valid_a, busy_a, lerr_a} !== 5'b11000) begin
            miscompares++;
            $display("FAIL rmid_ctrl got=%b exp=11000",
                     {csn_a, sclk_a, valid_a, busy_a, lerr_a});
        end
        vectors++;
        if (dout_a !== 24'h0) begin
            miscompares++;
            $display("FAIL rmid_data got=%h exp=000000", dout_a);
        end
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            vectors++;
            if ({csn_a, valid_a} !== 2'b10) begin
                miscompares++;
                $display("FAIL rmid_quiet k=%0d got=%b exp=10", k,
                         {csn_a, valid_a});
            end
        end
        fr = rand_frame(1'b0);
        fr[0] = 16'h0DBF;
        qa.push_back(fr);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= 137; k++) begin
            exp = pins(k, 1, 128, 8, 4);
            vectors++;
            if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                miscompares++;
                $display("FAIL rmid2_pins k=%0d got=%b exp=%b", k,
                         {csn_a, sclk_a, valid_a, busy_a}, exp);
            end
            if (exp[1]) begin
                vectors++;
                if ({lerr_a, dout_a} !== {lead_a(fr), data_a(fr)}) begin
                    miscompares++;
                    $display("FAIL rmid2_data got=%b_%h exp=%b_%h",
                             lerr_a, dout_a, lead_a(fr), data_a(fr));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_held();
        frame_a_t fr;
        logic [3:0] exp;
        int nv;
        nv = 0;
        fr = rand_frame(1'b1);
        qa.push_back(fr);
        start_a = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 160; k++) begin
            exp = pins(k, 1, 128, 8, 4);
            vectors++;
            if ({csn_a, sclk_a, valid_a, busy_a} !== exp) begin
                miscompares++;
                $display("FAIL held_pins k=%0d got=%b exp=%b", k,
                         {csn_a, sclk_a, valid_a, busy_a}, exp);
            end
            if (valid_a === 1'b1) nv++;
            if (k == 128) start_a = 1'b0;
            if (k == 132) start_a = 1'b1;
            if (k == 133) start_a = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (nv !== 1) begin
            miscompares++;
            $display("FAIL held_valid_count got=%0d exp=1", nv);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] bs[3];
        logic [3:0] exp;
        int nv;
        qb.push_back(8'hA5);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            exp = pins(k, 1, 16, 1, 1);
            vectors++;
            if ({csn_b, sclk_b, valid_b, busy_b} !== exp) begin
                miscompares++;
                $display("FAIL sweep_pins k=%0d got=%b exp=%b", k,
                         {csn_b, sclk_b, valid_b, busy_b}, exp);
            end
            if (exp[1]) begin
                vectors++;
                if ({lerr_b, dout_b} !== {1'b0, 8'hA5}) begin
                    miscompares++;
                    $display("FAIL sweep_data got=%b_%h exp=0_a5",
                             lerr_b, dout_b);
                end
            end
            @(negedge clk);
        end
        nv = 0;
        for (int i = 0; i < 3; i++) begin
            bs[i] = 8'($urandom);
            qb.push_back(bs[i]);
        end
        cont_b = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 60; k++) begin
            exp = pins(k, 3, 16, 1, 1);
            vectors++;
            if ({csn_b, sclk_b, valid_b, busy_b} !== exp) begin
                miscompares++;
                $display("FAIL sweep_cont_pins k=%0d got=%b exp=%b", k,
                         {csn_b, sclk_b, valid_b, busy_b}, exp);
            end
            if (exp[1]) begin
                vectors++;
                if ({lerr_b, dout_b} !== {1'b0, bs[nv]}) begin
                    miscompares++;
                    $display("FAIL sweep_cont_data k=%0d got=%h exp=%h",
                             k, dout_b, bs[nv]);
                end
                if (nv < 2) nv++;
            end
            if (k == 40) cont_b = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_lead_err();
        test_random();
        test_reset_mid();
        test_start_held();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
